// File: rtl/pe_pkg.sv
// Shared widths, limits and the output clamp helper for the processing-element
// requantization path.
package pe_pkg;

    localparam int ACC_WIDTH          = 32;
    localparam int OUT_WIDTH          = 8;
    localparam int MULT_WIDTH         = 16;
    localparam int SHIFT_WIDTH        = 5;
    localparam int SAT_CNT_WIDTH      = 16;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int PROD_WIDTH         = ACC_WIDTH + MULT_WIDTH + 1;
    localparam int SUM_WIDTH          = PROD_WIDTH + 1;

    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = 8'sh7F;
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = 8'sh80;
    localparam logic signed [SUM_WIDTH-1:0] SUM_MAX = 50'sd127;
    localparam logic signed [SUM_WIDTH-1:0] SUM_MIN = -50'sd128;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 sat;
    } clamp_t;

    function automatic clamp_t clamp_sum(input logic signed [SUM_WIDTH-1:0] sum);
        clamp_t res;
        if (sum > SUM_MAX) begin
            res.data = OUT_MAX;
            res.sat  = 1'b1;
        end else if (sum < SUM_MIN) begin
            res.data = OUT_MIN;
            res.sat  = 1'b1;
        end else begin
            res.data = sum[OUT_WIDTH-1:0];
            res.sat  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_out_fifo.sv
// Small synchronous output FIFO; the head entry is read straight from the
// storage registers, so a push into an empty FIFO shows up the next cycle.
module pe_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && (count_r != CNT_W'(DEPTH));
    assign do_pop_s  = pop && (count_r != '0);

    // Storage, power-of-two pointers (natural wrap) and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/pe_requant.sv
// Requantization stage behind the MAC array: scale, round, add zero point,
// saturate to int8, buffer, and count saturation events.
module pe_requant
    import pe_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ACC_WIDTH-1:0]     acc_in,
    input  logic                     acc_valid,
    output logic                     acc_ready,
    input  logic [MULT_WIDTH-1:0]    scale_mult,
    input  logic [SHIFT_WIDTH-1:0]   scale_shift,
    input  logic [OUT_WIDTH-1:0]     zero_point,
    output logic [OUT_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SAT_CNT_WIDTH-1:0] sat_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic                          accept_s;
    logic                          pop_s;
    logic signed [PROD_WIDTH-1:0]  prod_s;
    logic                          s1_valid_r;
    logic signed [PROD_WIDTH-1:0]  s1_prod_r;
    logic [SHIFT_WIDTH-1:0]        s1_shift_r;
    logic [OUT_WIDTH-1:0]          s1_zp_r;
    logic signed [SUM_WIDTH-1:0]   prod_ext_s;
    logic signed [SUM_WIDTH-1:0]   rnd_s;
    logic signed [SUM_WIDTH-1:0]   sh_s;
    logic signed [SUM_WIDTH-1:0]   zp_ext_s;
    logic signed [SUM_WIDTH-1:0]   sum_s;
    logic                          s2_valid_r;
    logic signed [SUM_WIDTH-1:0]   s2_sum_r;
    clamp_t                        clamp_s;
    logic [CNT_W-1:0]              fifo_count_s;
    logic [OCC_W-1:0]              occupancy_s;
    logic [SAT_CNT_WIDTH-1:0]      sat_count_r;

    // Credits cover every result already committed to the FIFO or still in
    // flight, so the non-stalling pipeline can never overrun the buffer.
    assign occupancy_s = OCC_W'(fifo_count_s) + OCC_W'(s1_valid_r) + OCC_W'(s2_valid_r);
    assign acc_ready   = (occupancy_s < OCC_W'(FIFO_DEPTH));
    assign accept_s    = acc_valid && acc_ready;

    assign prod_s = $signed(acc_in) * $signed({1'b0, scale_mult});

    // Stage 1: product plus the scale parameters that travel with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_prod_r  <= '0;
            s1_shift_r <= '0;
            s1_zp_r    <= '0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_prod_r  <= prod_s;
                s1_shift_r <= scale_shift;
                s1_zp_r    <= zero_point;
            end
        end
    end

    // Round-half-up constant: half an LSB of the shifted result.
    always_comb begin
        rnd_s = '0;
        if (s1_shift_r != 5'd0) begin
            rnd_s = {{(SUM_WIDTH-1){1'b0}}, 1'b1} << (s1_shift_r - 5'd1);
        end else begin
            rnd_s = '0;
        end
    end

    assign prod_ext_s = {s1_prod_r[PROD_WIDTH-1], s1_prod_r};
    assign zp_ext_s   = {{(SUM_WIDTH-OUT_WIDTH){s1_zp_r[OUT_WIDTH-1]}}, s1_zp_r};
    assign sh_s       = (prod_ext_s + rnd_s) >>> s1_shift_r;
    assign sum_s      = sh_s + zp_ext_s;

    // Stage 2: shifted, rounded and offset sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_sum_r   <= '0;
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_sum_r <= sum_s;
            end
        end
    end

    assign clamp_s = clamp_sum(s2_sum_r);

    // Saturation event counter, pinned at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_r <= '0;
        end else if (s2_valid_r && clamp_s.sat && (sat_count_r != 16'hFFFF)) begin
            sat_count_r <= sat_count_r + 16'd1;
        end
    end

    assign out_valid = (fifo_count_s != '0);
    assign pop_s     = out_valid && out_ready;
    assign sat_count = sat_count_r;

    pe_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s2_valid_r),
        .push_data (clamp_s.data),
        .pop       (pop_s),
        .head_data (out_data),
        .count     (fifo_count_s)
    );

endmodule

// File: tb/tb_pe_requant.sv
// Directed self-checking bench for pe_requant with an in-order result
// scoreboard fed from a reference model of the requantization arithmetic.
module tb_pe_requant;

    logic               clk;
    logic               rst;
    logic signed [31:0] acc_in;
    logic               acc_valid;
    logic               acc_ready;
    logic [15:0]        scale_mult;
    logic [4:0]         scale_shift;
    logic signed [7:0]  zero_point;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        sat_count;

    int          checks = 0;
    int          errors = 0;
    int          cycles = 0;
    logic [7:0]  q[$];

    pe_requant dut (
        .clk         (clk),
        .rst         (rst),
        .acc_in      (acc_in),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .scale_mult  (scale_mult),
        .scale_shift (scale_shift),
        .zero_point  (zero_point),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sat_count   (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycles <= cycles + 1;

    function automatic logic [7:0] model(input longint acc, input longint mult,
                                         input int shift, input longint zp);
        longint p;
        longint r;
        longint s;
        p = acc * mult;
        r = (shift == 0) ? 64'sd0 : (longint'(1) << (shift - 1));
        s = ((p + r) >>> shift) + zp;
        if (s > 127) return 8'h7F;
        if (s < -128) return 8'h80;
        return s[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one input and hold it until accepted; the expected result is queued on acceptance.
    task automatic send(input logic signed [31:0] a, input logic [15:0] m,
                        input logic [4:0] sh, input logic signed [7:0] zp);
        bit ok;
        int n;
        acc_in      = a;
        scale_mult  = m;
        scale_shift = sh;
        zero_point  = zp;
        acc_valid   = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = acc_ready;
            @(posedge clk);
            #1;
            n++;
        end
        acc_valid = 1'b0;
        if (ok) q.push_back(model(longint'(a), longint'(m), int'(sh), longint'(zp)));
        else check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", q.size(), 32'd0);
    endtask

    // Scoreboard: compare the head on every handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                check("out_data", 32'(out_data), 32'(q.pop_front()));
            end
        end
    end

    initial begin
        int  idx;
        int  n;
        int  t0;
        bit  ok;
        bit  seen;
        logic signed [31:0] bp_acc [6];

        rst = 1'b1;
        acc_in = '0;
        acc_valid = 1'b0;
        scale_mult = '0;
        scale_shift = '0;
        zero_point = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_acc_ready", 32'(acc_ready), 32'd1);
        check("rst_sat_count", 32'(sat_count), 32'd0);

        // Latency: with the acceptance edge counted as the first, out_valid rises after the third.
        out_ready = 1'b1;
        send(32'sd200, 16'd16384, 5'd15, 8'sd0);
        check("lat_edge1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_edge2", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_edge3", 32'(out_valid), 32'd1);
        check("lat_value", 32'(out_data), 32'd100);
        drain();
        check("sat_zero", 32'(sat_count), 32'd0);

        send(32'sd3, 16'd1, 5'd1, 8'sd0);
        send(-32'sd3, 16'd1, 5'd1, 8'sd0);
        send(32'sd5, 16'd1, 5'd0, -8'sd5);
        send(32'sd7, 16'd3, 5'd2, 8'sd10);
        drain();

        send(32'sd1000, 16'd1, 5'd0, 8'sd0);
        send(-32'sd1000, 16'd1, 5'd0, 8'sd0);
        drain();
        check("sat_two", 32'(sat_count), 32'd2);

        // Backpressure: consumer stalled, six offers, only four credits.
        for (int k = 0; k < 6; k++) bp_acc[k] = 32'(10 * (k + 1));
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            if (idx < 6) begin
                acc_in = bp_acc[idx]; scale_mult = 16'd1; scale_shift = 5'd0;
                zero_point = 8'(idx); acc_valid = 1'b1;
            end else begin
                acc_valid = 1'b0;
            end
            @(negedge clk); ok = acc_ready;
            @(posedge clk);
            if (ok && acc_valid) begin
                q.push_back(model(longint'(bp_acc[idx]), 64'sd1, 0, longint'(idx)));
                idx++;
            end
            #1;
        end
        check("bp_accepted", idx, 32'd4);
        check("bp_acc_ready", 32'(acc_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head_hold", 32'(out_data), 32'(q[0]));
        out_ready = 1'b1;
        n = 0;
        while (idx < 6 && n < 50) begin
            acc_in = bp_acc[idx]; scale_mult = 16'd1; scale_shift = 5'd0;
            zero_point = 8'(idx); acc_valid = 1'b1;
            @(negedge clk); ok = acc_ready;
            @(posedge clk);
            if (ok) begin
                q.push_back(model(longint'(bp_acc[idx]), 64'sd1, 0, longint'(idx)));
                idx++;
            end
            #1;
            n++;
        end
        acc_valid = 1'b0;
        check("bp_resume", idx, 32'd6);
        drain();

        // Full rate: sixteen back-to-back values must take sixteen cycles.
        t0 = cycles;
        for (int k = 0; k < 16; k++) begin
            send(32'(k * 1000 - 7000), 16'(300 + k), 5'(k), 8'(k - 8));
        end
        check("full_rate_cycles", cycles - t0, 32'd16);
        drain();

        for (int k = 0; k < 65537; k++) begin
            send((k % 2 == 0) ? 32'sd1000 : -32'sd1000, 16'd1, 5'd0, 8'sd0);
        end
        drain();
        check("sat_sticky", 32'(sat_count), 32'h0000FFFF);

        // Reset while two results sit in the FIFO and two are in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(32'sd1000, 16'd1, 5'd0, 8'sd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sat_count", 32'(sat_count), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("post_rst_acc_ready", 32'(acc_ready), 32'd1);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("no_stale_output", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
